mips_control_fsm: RTL and testbench

Multicycle control unit for the mini MIPS processor: the producer end of the ALU interface. Decodes the instruction register, sequences each instruction through fetch, decode, execute, memory and write-back states, and drives `alu_op` into the ALU. Consumes the ALU `equal` flag to resolve branches. Handshakes with the unified instruction/data memory and counts retired instructions.

---
 rtl/mips_control_fsm.sv | 187 ++++++++++++++++++
 tb/tb_mips_control_fsm.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_control_fsm.sv
// Multicycle control unit for the mini MIPS core: decodes the instruction register,
// sequences fetch/decode/execute/memory/write-back and counts retired instructions.
module mips_control_fsm (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [5:0]  opcode,
  input  logic [5:0]  funct,
  input  logic        alu_equal,
  input  logic        mem_ready,
  output logic [2:0]  alu_op,
  output logic        alu_src_a,
  output logic [1:0]  alu_src_b,
  output logic        imm_zext,
  output logic        i_or_d,
  output logic        mem_read,
  output logic        mem_write,
  output logic        ir_write,
  output logic        reg_dst,
  output logic        mem_to_reg,
  output logic        reg_write,
  output logic        pc_write,
  output logic [1:0]  pc_source,
  output logic        retired,
  output logic        illegal,
  output logic [31:0] instr_count
);

  localparam logic [5:0] OpRtype = 6'b000000;
  localparam logic [5:0] OpAddi  = 6'b001000;
  localparam logic [5:0] OpAndi  = 6'b001100;
  localparam logic [5:0] OpOri   = 6'b001101;
  localparam logic [5:0] OpLw    = 6'b100011;
  localparam logic [5:0] OpSw    = 6'b101011;
  localparam logic [5:0] OpBeq   = 6'b000100;
  localparam logic [5:0] OpBne   = 6'b000101;
  localparam logic [5:0] OpJ     = 6'b000010;

  localparam logic [2:0] AluAdd = 3'b000;
  localparam logic [2:0] AluSub = 3'b001;
  localparam logic [2:0] AluAnd = 3'b010;
  localparam logic [2:0] AluOr  = 3'b011;
  localparam logic [2:0] AluXor = 3'b100;
  localparam logic [2:0] AluNor = 3'b101;
  localparam logic [2:0] AluSlt = 3'b110;

  typedef enum logic [3:0] {
    StFetch, StDecode, StMemAddr, StMemRead, StMemWb, StMemWrite, StRExec,
    StRWb, StIExec, StIWb, StBranch, StJump, StIllegal
  } state_e;

  state_e     state;
  logic       r_legal;
  logic [2:0] r_op;

  // R-type funct decode: legality and the ALU operation it selects.
  always_comb begin
    r_legal = 1'b1;
    r_op    = AluAdd;
    case (funct)
      6'b100000: r_op = AluAdd;
      6'b100010: r_op = AluSub;
      6'b100100: r_op = AluAnd;
      6'b100101: r_op = AluOr;
      6'b100110: r_op = AluXor;
      6'b100111: r_op = AluNor;
      6'b101010: r_op = AluSlt;
      default:   r_legal = 1'b0;
    endcase
  end

  // State sequencing and the retired-instruction counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= StFetch;
      instr_count <= 32'd0;
    end else begin
      if (retired) instr_count <= instr_count + 32'd1;
      case (state)
        StFetch:    if (mem_ready) state <= StDecode;
        StDecode: begin
          case (opcode)
            OpLw, OpSw:             state <= StMemAddr;
            OpRtype:                state <= r_legal ? StRExec : StIllegal;
            OpAddi, OpAndi, OpOri:  state <= StIExec;
            OpBeq, OpBne:           state <= StBranch;
            OpJ:                    state <= StJump;
            default:                state <= StIllegal;
          endcase
        end
        StMemAddr:  state <= (opcode == OpLw) ? StMemRead : StMemWrite;
        StMemRead:  if (mem_ready) state <= StMemWb;
        StMemWrite: if (mem_ready) state <= StFetch;
        StRExec:    state <= StRWb;
        StIExec:    state <= StIWb;
        default:    state <= StFetch;
      endcase
    end
  end

  // Moore output decode; everything is held low while reset is asserted so the
  // FETCH strobes cannot write during reset.
  always_comb begin
    alu_op     = AluAdd;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'b00;
    imm_zext   = 1'b0;
    i_or_d     = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    reg_write  = 1'b0;
    pc_write   = 1'b0;
    pc_source  = 2'b00;
    retired    = 1'b0;
    illegal    = 1'b0;
    if (rst_n) begin
      unique case (state)
        StFetch: begin
          mem_read  = 1'b1;
          alu_src_b = 2'b01;
          ir_write  = mem_ready;
          pc_write  = mem_ready;
        end
        StDecode:  alu_src_b = 2'b11;
        StMemAddr: begin
          alu_src_a = 1'b1;
          alu_src_b = 2'b10;
        end
        StMemRead: begin
          mem_read = 1'b1;
          i_or_d   = 1'b1;
        end
        StMemWb: begin
          reg_write  = 1'b1;
          mem_to_reg = 1'b1;
          retired    = 1'b1;
        end
        StMemWrite: begin
          mem_write = 1'b1;
          i_or_d    = 1'b1;
          retired   = mem_ready;
        end
        StRExec: begin
          alu_src_a = 1'b1;
          alu_op    = r_op;
        end
        StRWb: begin
          reg_write = 1'b1;
          reg_dst   = 1'b1;
          retired   = 1'b1;
        end
        StIExec: begin
          alu_src_a = 1'b1;
          alu_src_b = 2'b10;
          if (opcode == OpAndi) begin
            alu_op   = AluAnd;
            imm_zext = 1'b1;
          end else if (opcode == OpOri) begin
            alu_op   = AluOr;
            imm_zext = 1'b1;
          end
        end
        StIWb: begin
          reg_write = 1'b1;
          retired   = 1'b1;
        end
        StBranch: begin
          alu_op    = AluSub;
          alu_src_a = 1'b1;
          pc_source = 2'b01;
          pc_write  = (opcode == OpBeq) ? alu_equal : !alu_equal;
          retired   = 1'b1;
        end
        StJump: begin
          pc_write  = 1'b1;
          pc_source = 2'b10;
          retired   = 1'b1;
        end
        StIllegal: illegal = 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mips_control_fsm.sv
// Self-checking bench for mips_control_fsm: a per-instruction model expands each
// instruction into its expected per-cycle output vectors, compared on every negedge.
module tb_mips_control_fsm;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [5:0]  opcode = 6'd0;
  logic [5:0]  funct = 6'd0;
  logic        alu_equal = 1'b0;
  logic        mem_ready = 1'b0;
  logic [2:0]  alu_op;
  logic        alu_src_a;
  logic [1:0]  alu_src_b;
  logic        imm_zext, i_or_d, mem_read, mem_write, ir_write;
  logic        reg_dst, mem_to_reg, reg_write, pc_write;
  logic [1:0]  pc_source;
  logic        retired, illegal;
  logic [31:0] instr_count;

  mips_control_fsm dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct), .alu_equal(alu_equal),
    .mem_ready(mem_ready), .alu_op(alu_op), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .imm_zext(imm_zext), .i_or_d(i_or_d), .mem_read(mem_read), .mem_write(mem_write),
    .ir_write(ir_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .reg_write(reg_write),
    .pc_write(pc_write), .pc_source(pc_source), .retired(retired), .illegal(illegal),
    .instr_count(instr_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0] alu_op;
    logic       src_a;
    logic [1:0] src_b;
    logic       zext;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       pc_write;
    logic [1:0] pc_source;
    logic       retired;
    logic       illegal;
  } outs_t;

  typedef struct packed {
    outs_t       o;
    logic [31:0] cnt;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] model_cnt = 32'd0;
  int          vectors = 0;
  int          miscompares = 0;

  localparam int KR = 0, KI = 1, KLw = 2, KSw = 3, KBr = 4, KJ = 5, KIll = 6;

  // ALU operation an R-type funct selects, or -1 when the funct is not decodable.
  function automatic int r_alu(input logic [5:0] fn);
    case (fn)
      6'b100000: return 0;
      6'b100010: return 1;
      6'b100100: return 2;
      6'b100101: return 3;
      6'b100110: return 4;
      6'b100111: return 5;
      6'b101010: return 6;
      default:   return -1;
    endcase
  endfunction

  function automatic int kind_of(input logic [5:0] op, input logic [5:0] fn);
    case (op)
      6'b000000:                   return (r_alu(fn) >= 0) ? KR : KIll;
      6'b001000, 6'b001100, 6'b001101: return KI;
      6'b100011:                   return KLw;
      6'b101011:                   return KSw;
      6'b000100, 6'b000101:        return KBr;
      6'b000010:                   return KJ;
      default:                     return KIll;
    endcase
  endfunction

  // Compare process: every cycle with a queued expectation is checked at the negedge.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t  e;
      outs_t act;
      e = exp_q.pop_front();
      act.alu_op = alu_op;       act.src_a = alu_src_a;     act.src_b = alu_src_b;
      act.zext = imm_zext;       act.i_or_d = i_or_d;       act.mem_read = mem_read;
      act.mem_write = mem_write; act.ir_write = ir_write;   act.reg_dst = reg_dst;
      act.mem_to_reg = mem_to_reg; act.reg_write = reg_write; act.pc_write = pc_write;
      act.pc_source = pc_source; act.retired = retired;     act.illegal = illegal;
      vectors++;
      if (act !== e.o || instr_count !== e.cnt) begin
        miscompares++;
        $display("FAIL cycle_outputs t=%0t op=%b fn=%b: got outs=%h cnt=%h, want outs=%h cnt=%h",
                 $time, opcode, funct, act, instr_count, e.o, e.cnt);
      end
    end
  end

  task automatic reset_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      exp_t e;
      @(posedge clk);
      #1;
      rst_n     = 1'b0;
      mem_ready = 1'($urandom);
      model_cnt = 32'd0;
      e.o   = '0;
      e.cnt = 32'd0;
      exp_q.push_back(e);
    end
  endtask

  // Expand one instruction into per-cycle expectations and drive it.
  // nf/nm: wait cycles in fetch and in the memory access; stop_at < 0 runs to completion;
  // lit >= 0 pins instr_count at the first cycle; do_force preloads the counter to all ones.
  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input logic eq,
                           input int nf, input int nm, input int stop_at,
                           input bit do_force, input longint lit);
    outs_t seq[$];
    logic  rdy[$];
    outs_t o;
    int    k;
    int    n;
    k = kind_of(op, fn);
    for (int i = 0; i <= nf; i++) begin
      o = '0; o.mem_read = 1'b1; o.src_b = 2'b01;
      o.ir_write = (i == nf); o.pc_write = (i == nf);
      seq.push_back(o); rdy.push_back(i == nf);
    end
    o = '0; o.src_b = 2'b11;
    seq.push_back(o); rdy.push_back(1'($urandom));
    case (k)
      KR: begin
        o = '0; o.src_a = 1'b1; o.alu_op = 3'(r_alu(fn));
        seq.push_back(o); rdy.push_back(1'($urandom));
        o = '0; o.reg_write = 1'b1; o.reg_dst = 1'b1; o.retired = 1'b1;
        seq.push_back(o); rdy.push_back(1'($urandom));
      end
      KI: begin
        o = '0; o.src_a = 1'b1; o.src_b = 2'b10;
        o.alu_op = (op == 6'b001000) ? 3'd0 : (op == 6'b001100) ? 3'd2 : 3'd3;
        o.zext = (op != 6'b001000);
        seq.push_back(o); rdy.push_back(1'($urandom));
        o = '0; o.reg_write = 1'b1; o.retired = 1'b1;
        seq.push_back(o); rdy.push_back(1'($urandom));
      end
      KLw, KSw: begin
        o = '0; o.src_a = 1'b1; o.src_b = 2'b10;
        seq.push_back(o); rdy.push_back(1'($urandom));
        for (int i = 0; i <= nm; i++) begin
          o = '0; o.i_or_d = 1'b1;
          if (k == KLw) o.mem_read = 1'b1;
          else begin
            o.mem_write = 1'b1;
            o.retired = (i == nm);
          end
          seq.push_back(o); rdy.push_back(i == nm);
        end
        if (k == KLw) begin
          o = '0; o.reg_write = 1'b1; o.mem_to_reg = 1'b1; o.retired = 1'b1;
          seq.push_back(o); rdy.push_back(1'($urandom));
        end
      end
      KBr: begin
        o = '0; o.alu_op = 3'd1; o.src_a = 1'b1; o.pc_source = 2'b01; o.retired = 1'b1;
        o.pc_write = (op == 6'b000100) ? eq : !eq;
        seq.push_back(o); rdy.push_back(1'($urandom));
      end
      KJ: begin
        o = '0; o.pc_write = 1'b1; o.pc_source = 2'b10; o.retired = 1'b1;
        seq.push_back(o); rdy.push_back(1'($urandom));
      end
      default: begin
        o = '0; o.illegal = 1'b1;
        seq.push_back(o); rdy.push_back(1'($urandom));
      end
    endcase
    n = (stop_at >= 0 && stop_at < seq.size()) ? stop_at : seq.size();
    for (int i = 0; i < n; i++) begin
      exp_t e;
      @(posedge clk);
      #1;
      rst_n = 1'b1; opcode = op; funct = fn; alu_equal = eq; mem_ready = rdy[i];
      if (i == 0 && lit >= 0) begin
        vectors++;
        if ({32'd0, instr_count} != lit) begin
          miscompares++;
          $display("FAIL count_literal: got %0d, want %0d", instr_count, lit);
        end
      end
      if (i == 0 && do_force) begin
        force dut.instr_count = 32'hFFFF_FFFF;
        #1;
        release dut.instr_count;
        model_cnt = 32'hFFFF_FFFF;
      end
      e.o   = seq[i];
      e.cnt = model_cnt;
      exp_q.push_back(e);
      if (seq[i].retired) model_cnt = model_cnt + 32'd1;
    end
  endtask

  logic [5:0] ops[12] = '{6'b000000, 6'b000000, 6'b000000, 6'b001000, 6'b001100, 6'b001101,
                          6'b100011, 6'b101011, 6'b000100, 6'b000101, 6'b000010, 6'b111111};
  logic [5:0] fns[8]  = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b100110, 6'b100111,
                          6'b101010, 6'b000001};

  initial begin
    reset_cycles(2);
    // Directed scenarios.
    run_instr(6'b000000, 6'b100000, 1'b0, 0, 0, -1, 1'b0, 0);   // add
    run_instr(6'b100011, 6'b000000, 1'b0, 0, 3, -1, 1'b0, 1);   // lw, 3 memory waits
    run_instr(6'b000100, 6'b000000, 1'b1, 0, 0, -1, 1'b0, 2);   // beq taken
    run_instr(6'b000100, 6'b000000, 1'b0, 0, 0, -1, 1'b0, 3);   // beq not taken
    run_instr(6'b000101, 6'b000000, 1'b1, 0, 0, -1, 1'b0, 4);   // bne not taken
    run_instr(6'b000101, 6'b000000, 1'b0, 0, 0, -1, 1'b0, 5);   // bne taken
    run_instr(6'b001100, 6'b000000, 1'b0, 1, 0, -1, 1'b0, 6);   // andi, fetch wait
    run_instr(6'b000000, 6'b101010, 1'b0, 0, 0, -1, 1'b0, 7);   // slt
    run_instr(6'b111111, 6'b000000, 1'b0, 0, 0, -1, 1'b0, 8);   // illegal opcode
    run_instr(6'b000000, 6'b000001, 1'b0, 0, 0, -1, 1'b0, 8);   // illegal funct
    run_instr(6'b101011, 6'b000000, 1'b0, 0, 3, 5, 1'b0, 8);    // sw abandoned in MEM_WRITE
    reset_cycles(1);
    run_instr(6'b000010, 6'b000000, 1'b0, 0, 0, -1, 1'b0, 0);   // j after reset
    run_instr(6'b000000, 6'b100010, 1'b0, 0, 0, -1, 1'b1, 1);   // sub, counter preloaded
    run_instr(6'b001000, 6'b000000, 1'b0, 0, 0, -1, 1'b0, 0);   // addi sees wrapped count
    // Randomized instruction stream.
    for (int t = 0; t < 250; t++) begin
      logic [5:0] op;
      logic [5:0] fn;
      op = ops[$urandom_range(0, 11)];
      if (op == 6'b111111 && $urandom_range(0, 1) == 1) op = 6'($urandom);
      fn = ($urandom_range(0, 3) == 0) ? 6'($urandom) : fns[$urandom_range(0, 7)];
      run_instr(op, fn, 1'($urandom), $urandom_range(0, 2), $urandom_range(0, 2), -1, 1'b0, -1);
      if ($urandom_range(0, 40) == 0) reset_cycles(1);
    end
    @(negedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
